// File: rtl/icache_axi_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_axi_if
// Description : AXI read-address and read-data channels between the icache
//               refill master and the interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_axi_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/icache_axi.sv
`default_nettype none
// ============================================================================
// Module      : icache_axi
// Description : Read-only AXI master for icache refills. Issues one burst
//               per cached line fill or uncached single-word fetch, gathers
//               the beats into a line buffer and pulses rend_o on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_axi #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'b0000
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     icache_rreq_i,
    input  wire logic [31:0]              icache_raddr_i,
    input  wire logic                     icache_uncache_req_i,
    input  wire logic [31:0]              icache_uc_addr_i,
    output logic                          rend_o,
    output logic [32*LINE_WORDS-1:0]      cacheline_rdata_o,
    output logic                          rerr_o,
    icache_axi_if.master                  axi
);

    localparam int               CNT_W     = $clog2(LINE_WORDS);
    localparam int               OFF_BITS  = CNT_W + 2;
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q,  state_d;
    logic [31:0]             araddr_q, araddr_d;
    logic [7:0]              arlen_q,  arlen_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic                    err_q,    err_d;
    logic [32*LINE_WORDS-1:0] line_q,  line_d;

    // rid carries no information for a single-outstanding master
    logic unused_rid;
    assign unused_rid = ^axi.rid;

    // State and datapath registers; async reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            line_q   <= line_d;
        end
    end

    // Next-state: arbitrate in IDLE (cached wins), hold AR until accepted,
    // collect beats until rlast, then one DONE cycle
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        line_d   = line_q;
        case (state_q)
            S_IDLE: begin
                if (icache_rreq_i) begin
                    araddr_d = icache_raddr_i & ADDR_MASK;
                    arlen_d  = 8'(LINE_WORDS - 1);
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_AR;
                end else if (icache_uncache_req_i) begin
                    araddr_d = icache_uc_addr_i;
                    arlen_d  = 8'd0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                if (axi.arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (axi.rvalid) begin
                    line_d[{cnt_q, 5'd0} +: 32] = axi.rdata;
                    err_d = err_q | (axi.rresp != 2'b00);
                    // Saturate so surplus beats land on the last word
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (axi.rlast) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registers or state decodes only
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (state_q == S_AR);
    assign axi.rready  = (state_q == S_R);

    assign rend_o            = (state_q == S_DONE);
    assign rerr_o            = (state_q == S_DONE) && err_q;
    assign cacheline_rdata_o = line_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_axi
// Description : Self-checking bench for icache_axi. Acts as the icache
//               requester and an AXI read slave; expected line contents,
//               error flag and latency come from a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_axi;

    localparam int LW = 8;

    logic                clk;
    logic                rst_n;
    logic                icache_rreq_i;
    logic [31:0]         icache_raddr_i;
    logic                icache_uncache_req_i;
    logic [31:0]         icache_uc_addr_i;
    logic                rend_o;
    logic [32*LW-1:0]    cacheline_rdata_o;
    logic                rerr_o;

    icache_axi_if axi_if ();

    icache_axi #(
        .LINE_WORDS (LW),
        .AXI_ID     (4'b0000)
    ) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .icache_rreq_i        (icache_rreq_i),
        .icache_raddr_i       (icache_raddr_i),
        .icache_uncache_req_i (icache_uncache_req_i),
        .icache_uc_addr_i     (icache_uc_addr_i),
        .rend_o               (rend_o),
        .cacheline_rdata_o    (cacheline_rdata_o),
        .rerr_o               (rerr_o),
        .axi                  (axi_if.master)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference line buffer: what the icache should see after each fill
    logic [31:0] exp_line [LW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic check_line(input string tag);
        for (int k = 0; k < LW; k++) begin
            check(tag, cacheline_rdata_o[k*32 +: 32], exp_line[k]);
        end
    endtask

    task automatic slave_idle();
        axi_if.arready = 1'b0;
        axi_if.rvalid  = 1'b0;
        axi_if.rlast   = 1'b0;
        axi_if.rresp   = 2'b00;
        axi_if.rdata   = 32'h0;
        axi_if.rid     = 4'h0;
    endtask

    // One transaction. Caller raises the request at the negedge of cycle 0.
    // gap_mode: 0 back-to-back, 1 rvalid every other cycle, 2 random.
    task automatic run_txn(input bit unc, input logic [31:0] addr,
                           input int ar_delay, input int gap_mode,
                           input int err_beat, input int nbeats,
                           input bit directed, input logic [31:0] dbase,
                           output int rend_cyc);
        int          cyc, ar_wait, r_gaps, beat, r_cyc, idx;
        bit          seen_ar, done, err_exp, v;
        logic [31:0] d, exp_addr;
        exp_addr = unc ? addr : (addr & ~(32'(LW * 4) - 32'd1));
        cyc = 0; ar_wait = 0; r_gaps = 0; beat = 0; r_cyc = 0;
        seen_ar = 1'b0; done = 1'b0; err_exp = 1'b0; rend_cyc = -1;
        while (!done && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            slave_idle();
            if (rend_o) begin
                rend_cyc = cyc;
                check("rend_cycle", cyc, nbeats + 2 + ar_delay + r_gaps);
                check("rerr", {31'd0, rerr_o}, {31'd0, err_exp});
                check_line("line_word");
                if (unc) icache_uncache_req_i = 1'b0;
                else     icache_rreq_i        = 1'b0;
                done = 1'b1;
            end else if (axi_if.arvalid) begin
                if (!seen_ar) check("ar_start", cyc, 1);
                seen_ar = 1'b1;
                check("araddr", axi_if.araddr, exp_addr);
                check("arlen", {24'd0, axi_if.arlen}, unc ? 32'd0 : 32'(LW - 1));
                if (ar_wait >= ar_delay) axi_if.arready = 1'b1;
                else                     ar_wait++;
            end else if (axi_if.rready) begin
                case (gap_mode)
                    0:       v = 1'b1;
                    1:       v = (r_cyc % 2 == 0);
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                r_cyc++;
                if (v) begin
                    d = directed ? dbase + 32'(beat) : $urandom;
                    axi_if.rvalid = 1'b1;
                    axi_if.rdata  = d;
                    axi_if.rid    = 4'($urandom);
                    axi_if.rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
                    axi_if.rlast  = (beat == nbeats - 1);
                    idx = (beat < LW) ? beat : LW - 1;
                    exp_line[idx] = d;
                    if (beat == err_beat) err_exp = 1'b1;
                    beat++;
                end else begin
                    r_gaps++;
                end
            end
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            icache_rreq_i        = 1'b0;
            icache_uncache_req_i = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            check("rend_single", {31'd0, rend_o}, 32'd0);
        end
    endtask

    int          rc;
    bit          unc_r;
    int          nb, errb;
    logic [31:0] a;

    initial begin
        rst_n                = 1'b0;
        icache_rreq_i        = 1'b0;
        icache_raddr_i       = 32'h0;
        icache_uncache_req_i = 1'b0;
        icache_uc_addr_i     = 32'h0;
        slave_idle();
        for (int k = 0; k < LW; k++) exp_line[k] = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_arvalid", {31'd0, axi_if.arvalid}, 32'd0);
        check("rst_rready",  {31'd0, axi_if.rready},  32'd0);
        check("rst_rend",    {31'd0, rend_o},         32'd0);
        check("rst_rerr",    {31'd0, rerr_o},         32'd0);
        check("rst_araddr",  axi_if.araddr,           32'd0);
        check("rst_arlen",   {24'd0, axi_if.arlen},   32'd0);
        check("rst_arsize",  {29'd0, axi_if.arsize},  32'd2);
        check("rst_arburst", {30'd0, axi_if.arburst}, 32'd1);
        check("rst_arid",    {28'd0, axi_if.arid},    32'd0);
        check_line("rst_line");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cached fill, immediate ready, back-to-back beats
        icache_raddr_i = 32'h1FC0_0014; icache_rreq_i = 1'b1;
        run_txn(1'b0, 32'h1FC0_0014, 0, 0, -1, LW, 1'b1, 32'hA0, rc);
        check("t1_latency", rc, 10);

        // Same fill with AR stalled 3 cycles and rvalid every other cycle
        icache_raddr_i = 32'h1FC0_0014; icache_rreq_i = 1'b1;
        run_txn(1'b0, 32'h1FC0_0014, 3, 1, -1, LW, 1'b1, 32'hA0, rc);
        check("t2_latency", rc, 20);

        // Uncached fetch: only word 0 changes
        icache_uc_addr_i = 32'hBFC0_0004; icache_uncache_req_i = 1'b1;
        run_txn(1'b1, 32'hBFC0_0004, 0, 0, -1, 1, 1'b1, 32'h3C1D_0000, rc);
        check("t3_latency", rc, 3);

        // Both requests together: cached first, uncached afterwards
        icache_raddr_i   = 32'h0040_1238; icache_rreq_i        = 1'b1;
        icache_uc_addr_i = 32'h8000_0010; icache_uncache_req_i = 1'b1;
        run_txn(1'b0, 32'h0040_1238, 0, 0, -1, LW, 1'b0, 32'h0, rc);
        run_txn(1'b1, 32'h8000_0010, 1, 0, -1, 1, 1'b0, 32'h0, rc);

        // Error on beat 4, then a clean fill
        icache_raddr_i = 32'h0000_2000; icache_rreq_i = 1'b1;
        run_txn(1'b0, 32'h0000_2000, 0, 0, 4, LW, 1'b0, 32'h0, rc);
        icache_raddr_i = 32'h0000_2040; icache_rreq_i = 1'b1;
        run_txn(1'b0, 32'h0000_2040, 0, 0, -1, LW, 1'b0, 32'h0, rc);

        // Surplus beats past the line length overwrite the last word
        icache_raddr_i = 32'h0000_3000; icache_rreq_i = 1'b1;
        run_txn(1'b0, 32'h0000_3000, 0, 2, -1, LW + 2, 1'b0, 32'h0, rc);

        // Reset asserted while beat 3 is on the bus
        icache_raddr_i = 32'h0000_4000; icache_rreq_i = 1'b1;
        begin
            int b3;
            bit hit;
            b3 = 0; hit = 1'b0;
            for (int c = 0; c < 40 && !hit; c++) begin
                @(posedge clk);
                @(negedge clk);
                slave_idle();
                if (axi_if.arvalid) axi_if.arready = 1'b1;
                else if (axi_if.rready) begin
                    axi_if.rvalid = 1'b1;
                    axi_if.rdata  = $urandom;
                    if (b3 == 3) hit = 1'b1;
                    b3++;
                end
            end
            check("rst_mid_reached", {31'd0, hit}, 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("rst_mid_rready",  {31'd0, axi_if.rready},  32'd0);
            check("rst_mid_arvalid", {31'd0, axi_if.arvalid}, 32'd0);
            for (int k = 0; k < LW; k++) exp_line[k] = 32'h0;
            check_line("rst_mid_line");
            icache_rreq_i = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                slave_idle();
                if (c == 1) rst_n = 1'b1;
                check("rst_mid_no_rend", {31'd0, rend_o}, 32'd0);
            end
        end
        icache_raddr_i = 32'h0000_4000; icache_rreq_i = 1'b1;
        run_txn(1'b0, 32'h0000_4000, 0, 0, -1, LW, 1'b0, 32'h0, rc);

        // Randomised mix
        for (int i = 0; i < 24; i++) begin
            unc_r = ($urandom_range(0, 3) == 0);
            a     = $urandom;
            nb    = unc_r ? 1 : (($urandom_range(0, 3) == 0) ? LW + int'($urandom_range(1, 2)) : LW);
            errb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            if (unc_r) begin
                icache_uc_addr_i = a; icache_uncache_req_i = 1'b1;
            end else begin
                icache_raddr_i = a; icache_rreq_i = 1'b1;
            end
            run_txn(unc_r, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    errb, nb, 1'b0, 32'h0, rc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case of a stuck handshake outside run_txn
    initial begin
        #500000;
        $display("FAIL watchdog got=%08h exp=%08h", 32'd0, 32'd1);
        $fatal(1);
    end

endmodule
`default_nettype wire
